// File: rtl/acq_sequencer_if.sv
// Host/packetizer-facing signal bundle for acq_sequencer: command, config,
// status, packetizer control and S2MM monitor taps.
interface acq_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 cmd_start;
    logic                 cmd_abort;
    logic [31:0]          cfg_packet_len;
    logic [CNT_WIDTH-1:0] cfg_num_packets;
    logic                 mon_tvalid;
    logic                 mon_tready;
    logic                 mon_tlast;
    logic                 pkt_aresetn;
    logic [31:0]          pkt_config;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 cfg_error;
    logic [CNT_WIDTH-1:0] packets_done;
    logic [31:0]          beats_done;
    logic                 irq;
    logic                 irq_ack;

    // Host / environment side
    modport master (
        output cmd_start, cmd_abort, cfg_packet_len, cfg_num_packets,
        output mon_tvalid, mon_tready, mon_tlast, irq_ack,
        input  pkt_aresetn, pkt_config, busy, done, aborted, cfg_error,
        input  packets_done, beats_done, irq
    );

    // Sequencer side
    modport slave (
        input  cmd_start, cmd_abort, cfg_packet_len, cfg_num_packets,
        input  mon_tvalid, mon_tready, mon_tlast, irq_ack,
        output pkt_aresetn, pkt_config, busy, done, aborted, cfg_error,
        output packets_done, beats_done, irq
    );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms a packetizer by pulsing its reset, counts S2MM beats/packets, reports done/abort.
// Optional interrupt output enabled by defining ACQ_SEQUENCER_IRQ_EN.
module acq_sequencer #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic           aclk,
    input  logic           aresetn,
    acq_sequencer_if.slave bus
);
    localparam int unsigned LEN_W  = 32;
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned ARM_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(RESET_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    logic [1:0]           state_q, state_d;
    logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] packets_q, packets_d;
    logic [BEAT_W-1:0]    beats_q, beats_d;
    logic                 aborted_q, aborted_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 pkt_aresetn_q, pkt_aresetn_d;
    logic [LEN_W-1:0]     pkt_config_q, pkt_config_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hs;
    logic                 cfg_ok;

    assign hs     = bus.mon_tvalid & bus.mon_tready;
    assign cfg_ok = (bus.cfg_packet_len != '0) && (bus.cfg_num_packets != '0);

    // Next state, counters and registered outputs derived from the next state
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        len_d       = len_q;
        num_d       = num_q;
        packets_d   = packets_q;
        beats_d     = beats_q;
        aborted_d   = aborted_q;
        cfg_error_d = cfg_error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    if (cfg_ok) begin
                        len_d       = bus.cfg_packet_len;
                        num_d       = bus.cfg_num_packets;
                        packets_d   = '0;
                        beats_d     = '0;
                        aborted_d   = 1'b0;
                        cfg_error_d = 1'b0;
                        arm_cnt_d   = '0;
                        state_d     = S_ARM;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (bus.cmd_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = S_RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            S_RUN: begin
                // The final beat is still counted when an abort lands on it; abort then wins
                if (hs) begin
                    if (beats_q != BEAT_MAX) begin
                        beats_d = beats_q + BEAT_W'(1);
                    end
                    if (bus.mon_tlast) begin
                        packets_d = packets_q + CNT_WIDTH'(1);
                        if ((packets_q + CNT_WIDTH'(1)) == num_q) begin
                            state_d = S_FINISH;
                        end
                    end
                end
                if (bus.cmd_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pkt_aresetn_d = (state_d == S_RUN);
        pkt_config_d  = (state_d == S_RUN) ? len_d : '0;
        busy_d        = (state_d == S_ARM) || (state_d == S_RUN);
        done_d        = (state_d == S_FINISH);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            arm_cnt_q     <= '0;
            len_q         <= '0;
            num_q         <= '0;
            packets_q     <= '0;
            beats_q       <= '0;
            aborted_q     <= 1'b0;
            cfg_error_q   <= 1'b0;
            pkt_aresetn_q <= 1'b0;
            pkt_config_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            len_q         <= len_d;
            num_q         <= num_d;
            packets_q     <= packets_d;
            beats_q       <= beats_d;
            aborted_q     <= aborted_d;
            cfg_error_q   <= cfg_error_d;
            pkt_aresetn_q <= pkt_aresetn_d;
            pkt_config_q  <= pkt_config_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef ACQ_SEQUENCER_IRQ_EN
    logic irq_q, irq_d;

    // Set on a rising done/aborted; a coincident ack loses to the set
    always_comb begin
        irq_d = irq_q;
        if ((done_d && !done_q) || (aborted_d && !aborted_q)) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = bus.irq_ack;
    assign bus.irq        = 1'b0;
`endif

    assign bus.pkt_aresetn  = pkt_aresetn_q;
    assign bus.pkt_config   = pkt_config_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.cfg_error    = cfg_error_q;
    assign bus.packets_done = packets_q;
    assign bus.beats_done   = beats_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed scenarios plus random traffic, checked every cycle against a
// transaction-level reference model; emulates the packetizer's S2MM output stream.
module tb_acq_sequencer;
    localparam int unsigned RC = 2;
    localparam int unsigned CW = 16;

    logic aclk = 1'b0;
    logic aresetn;

    acq_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    acq_sequencer #(.RESET_CYCLES(RC), .CNT_WIDTH(CW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: acquisition-level view
    bit          m_active;
    int unsigned m_arm_left;
    bit          m_done;
    logic [31:0] m_len;
    int unsigned m_num;
    int unsigned m_pkts;
    logic [31:0] m_beats;
    bit          m_aborted;
    bit          m_cfg_err;
    bit          m_irq;

    // Packetizer emulation and observation counters
    int unsigned word_idx;
    bit          force_valid, force_ready, hold_mon, ack_rand;
    int          done_pulses, arm_cycles;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_arm_left = 0;
        m_done     = 1'b0;
        m_len      = '0;
        m_num      = 0;
        m_pkts     = 0;
        m_beats    = '0;
        m_aborted  = 1'b0;
        m_cfg_err  = 1'b0;
        m_irq      = 1'b0;
    endtask

    task automatic model_step();
        bit hs, prev_done, prev_ab;
        hs        = bus.mon_tvalid && bus.mon_tready;
        prev_done = m_done;
        prev_ab   = m_aborted;
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (bus.cmd_start) begin
                if (bus.cfg_packet_len != 0 && bus.cfg_num_packets != 0) begin
                    m_len      = bus.cfg_packet_len;
                    m_num      = 32'(bus.cfg_num_packets);
                    m_pkts     = 0;
                    m_beats    = '0;
                    m_aborted  = 1'b0;
                    m_cfg_err  = 1'b0;
                    m_active   = 1'b1;
                    m_arm_left = RC;
                end else begin
                    m_cfg_err = 1'b1;
                end
            end
        end else if (m_arm_left > 0) begin
            if (bus.cmd_abort) begin
                m_active  = 1'b0;
                m_aborted = 1'b1;
            end else begin
                m_arm_left--;
            end
        end else begin
            if (hs) begin
                if (m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 32'd1;
                if (bus.mon_tlast) m_pkts++;
            end
            if (bus.cmd_abort) begin
                m_active  = 1'b0;
                m_aborted = 1'b1;
            end else if (hs && bus.mon_tlast && m_pkts == m_num) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
`ifdef ACQ_SEQUENCER_IRQ_EN
        if ((m_done && !prev_done) || (m_aborted && !prev_ab)) m_irq = 1'b1;
        else if (bus.irq_ack) m_irq = 1'b0;
`else
        m_irq = 1'b0;
`endif
    endtask

    task automatic check_outputs();
        bit run;
        run = m_active && (m_arm_left == 0);
        check_eq("busy",         64'(bus.busy),         64'(m_active));
        check_eq("pkt_aresetn",  64'(bus.pkt_aresetn),  64'(run));
        check_eq("pkt_config",   64'(bus.pkt_config),   run ? 64'(m_len) : 64'd0);
        check_eq("done",         64'(bus.done),         64'(m_done));
        check_eq("aborted",      64'(bus.aborted),      64'(m_aborted));
        check_eq("cfg_error",    64'(bus.cfg_error),    64'(m_cfg_err));
        check_eq("packets_done", 64'(bus.packets_done), 64'(m_pkts));
        check_eq("beats_done",   64'(bus.beats_done),   64'(m_beats));
        check_eq("irq",          64'(bus.irq),          64'(m_irq));
    endtask

    // One clock: drive the stream as the packetizer would, step model, compare after the edge
    task automatic run_cycle();
        bit          pk_run;
        logic [31:0] plen;
        pk_run = (bus.pkt_aresetn === 1'b1);
        plen   = bus.pkt_config;
        if (!pk_run) word_idx = 0;
        if (hold_mon) begin
            bus.mon_tvalid = 1'b0;
            bus.mon_tready = 1'b0;
            bus.mon_tlast  = 1'b0;
        end else begin
            bus.mon_tvalid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
            bus.mon_tready = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
            bus.mon_tlast  = pk_run ? (word_idx == plen - 32'd1) : 1'($urandom_range(0, 1));
        end
        if (ack_rand) bus.irq_ack = ($urandom_range(0, 7) == 0);
        @(posedge aclk);
        model_step();
        if (pk_run && bus.mon_tvalid && bus.mon_tready)
            word_idx = bus.mon_tlast ? 0 : word_idx + 1;
        #1;
        check_outputs();
        if (bus.done === 1'b1) done_pulses++;
        if (bus.busy === 1'b1 && bus.pkt_aresetn === 1'b0) arm_cycles++;
    endtask

    task automatic pulse_start(input logic [31:0] len, input logic [CW-1:0] num);
        bus.cfg_packet_len  = len;
        bus.cfg_num_packets = num;
        bus.cmd_start       = 1'b1;
        run_cycle();
        bus.cmd_start       = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.cmd_abort = 1'b1;
        run_cycle();
        bus.cmd_abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.busy === 1'b1 || bus.done === 1'b1) && n < budget) begin
            run_cycle();
            n++;
        end
        check_eq({tag, "_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    task automatic wait_packets(input string tag, input int unsigned target, input int budget);
        int n;
        n = 0;
        while (32'(bus.packets_done) != target && n < budget) begin
            run_cycle();
            n++;
        end
        check_eq({tag, "_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        aresetn             = 1'b0;
        bus.cmd_start       = 1'b0;
        bus.cmd_abort       = 1'b0;
        bus.cfg_packet_len  = '0;
        bus.cfg_num_packets = '0;
        bus.mon_tvalid      = 1'b0;
        bus.mon_tready      = 1'b0;
        bus.mon_tlast       = 1'b0;
        bus.irq_ack         = 1'b0;
        force_valid = 0; force_ready = 0; hold_mon = 0; ack_rand = 0;
        word_idx = 0; done_pulses = 0; arm_cycles = 0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs();
        aresetn = 1'b1;

        // Nominal acquisition, sink always ready
        force_valid = 1; force_ready = 1;
        done_pulses = 0; arm_cycles = 0;
        pulse_start(32'd10, CW'(3));
        wait_idle("s1", 200);
        check_eq("s1_packets",     64'(bus.packets_done), 64'd3);
        check_eq("s1_beats",       64'(bus.beats_done),   64'd30);
        check_eq("s1_done_pulses", 64'(done_pulses),      64'd1);
        check_eq("s1_arm_cycles",  64'(arm_cycles),       64'(RC));
        repeat (3) run_cycle();
        check_eq("s1_hold_packets", 64'(bus.packets_done), 64'd3);

        // Zero configuration is rejected
        pulse_start(32'd10, CW'(0));
        check_eq("s2_cfg_error", 64'(bus.cfg_error), 64'd1);
        check_eq("s2_busy",      64'(bus.busy),      64'd0);
        repeat (3) run_cycle();
        check_eq("s2_pkt_rst",   64'(bus.pkt_aresetn), 64'd0);
        pulse_start(32'd0, CW'(2));
        check_eq("s2_cfg_error_len", 64'(bus.cfg_error), 64'd1);

        // Abort after the second packet; irq held until acknowledged
        done_pulses = 0;
        pulse_start(32'd10, CW'(5));
        wait_packets("s3", 2, 200);
        hold_mon = 1;
        pulse_abort();
        check_eq("s3_aborted", 64'(bus.aborted),      64'd1);
        check_eq("s3_packets", 64'(bus.packets_done), 64'd2);
        check_eq("s3_busy",    64'(bus.busy),         64'd0);
        repeat (3) run_cycle();
`ifdef ACQ_SEQUENCER_IRQ_EN
        check_eq("s3_irq_held", 64'(bus.irq), 64'd1);
`else
        check_eq("s3_irq_tied", 64'(bus.irq), 64'd0);
`endif
        bus.irq_ack = 1'b1;
        run_cycle();
        bus.irq_ack = 1'b0;
        check_eq("s3_irq_acked", 64'(bus.irq),    64'd0);
        check_eq("s3_no_done",   64'(done_pulses), 64'd0);
        hold_mon = 0;

        // Abort on the same cycle as the final tlast
        done_pulses = 0;
        pulse_start(32'd4, CW'(3));
        n = 0;
        while (!(bus.pkt_aresetn === 1'b1 && bus.packets_done == CW'(2) && word_idx == 3) && n < 100) begin
            run_cycle();
            n++;
        end
        check_eq("s4_timeout", 64'(n >= 100), 64'd0);
        pulse_abort();
        check_eq("s4_packets", 64'(bus.packets_done), 64'd3);
        check_eq("s4_beats",   64'(bus.beats_done),   64'd12);
        check_eq("s4_aborted", 64'(bus.aborted),      64'd1);
        repeat (3) run_cycle();
        check_eq("s4_no_done", 64'(done_pulses), 64'd0);
        bus.irq_ack = 1'b1;
        run_cycle();
        bus.irq_ack = 1'b0;

        // Second start while running is ignored
        pulse_start(32'd4, CW'(2));
        repeat (4) run_cycle();
        pulse_start(32'd7, CW'(9));
        wait_idle("s5", 200);
        check_eq("s5_packets", 64'(bus.packets_done), 64'd2);
        check_eq("s5_beats",   64'(bus.beats_done),   64'd8);
        bus.irq_ack = 1'b1;
        run_cycle();
        bus.irq_ack = 1'b0;

        // Asynchronous reset mid-run, then a fresh acquisition
        pulse_start(32'd6, CW'(4));
        repeat (8) run_cycle();
        #2;
        aresetn = 1'b0;
        #1;
        model_reset();
        word_idx = 0;
        check_outputs();
        check_eq("s6_rst_busy", 64'(bus.busy), 64'd0);
        @(posedge aclk);
        #1;
        check_outputs();
        #1;
        aresetn = 1'b1;
        done_pulses = 0;
        pulse_start(32'd4, CW'(1));
        wait_idle("s6", 100);
        check_eq("s6_packets",     64'(bus.packets_done), 64'd1);
        check_eq("s6_beats",       64'(bus.beats_done),   64'd4);
        check_eq("s6_done_pulses", 64'(done_pulses),      64'd1);

        // Random traffic, commands and acks
        force_valid = 0; force_ready = 0; ack_rand = 1;
        for (int i = 0; i < 2000; i++) begin
            bus.cmd_start = ($urandom_range(0, 11) == 0);
            bus.cmd_abort = ($urandom_range(0, 39) == 0);
            bus.cfg_packet_len  = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 4));
            bus.cfg_num_packets = CW'($urandom_range(0, 3));
            run_cycle();
        end
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        ack_rand      = 0;
        bus.irq_ack   = 1'b0;
        repeat (2) run_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, cycles the packetizer reset is held low during arming (min 1).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the packet-count configuration and status.
REQ-003 SHALL have aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cmd_start  input  1  single-cycle start request.
REQ-006 SHALL have cmd_abort  input  1  single-cycle abort request.
REQ-007 SHALL have cfg_packet_len  input  32  words per packet, sampled on accepted start.
REQ-008 SHALL have cfg_num_packets  input  CNT_WIDTH  packets per acquisition, sampled on accepted start.
REQ-009 SHALL have mon_tvalid, mon_tready, mon_tlast  input  1 each  monitor taps of the packetizer S2MM output stream.
REQ-010 SHALL have pkt_aresetn  output  1  active-low reset to the packetizer.
REQ-011 SHALL have pkt_config  output  32  packet-length register driven to the packetizer.
REQ-012 SHALL have busy, done, aborted, cfg_error  output  1 each  status (done is a one-cycle pulse; others levels).
REQ-013 SHALL have packets_done  output  CNT_WIDTH  completed packets in current/last acquisition.
REQ-014 SHALL have beats_done  output  32  handshaked beats in current/last acquisition, saturating at 2^32-1.
REQ-015 SHALL have irq  output  1, irq_ack  input  1 (see Configuration).

Function
REQ-016 SHALL implement states IDLE, ARM, RUN, FINISH.
REQ-017 IDLE: pkt_aresetn=0, pkt_config=0, busy=0.
REQ-018 IDLE + cmd_start with both cfg values nonzero: latch cfg, clear packets_done, beats_done, aborted, cfg_error; go ARM next cycle.
REQ-019 IDLE + cmd_start with either cfg value zero: set cfg_error, remain IDLE.
REQ-020 ARM: pkt_aresetn=0 for exactly RESET_CYCLES cycles, pkt_config=0, busy=1; then go RUN.
REQ-021 RUN: pkt_aresetn=1, pkt_config=latched length from the first RUN cycle, busy=1.
REQ-022 RUN: each cycle with mon_tvalid & mon_tready increments beats_done; if mon_tlast also high, increments packets_done.
REQ-023 RUN: tlast beat making packets_done equal latched count goes FINISH next cycle.
REQ-024 FINISH: one cycle; pkt_aresetn=0, pkt_config=0, done=1, busy=0; then IDLE.
REQ-025 cmd_start outside IDLE SHALL be ignored (no latch, no status change).
REQ-026 cmd_abort in ARM or RUN: go IDLE next cycle, set aborted, no done pulse; cmd_abort in IDLE/FINISH ignored.
REQ-027 cmd_abort coinciding with the final tlast beat: the beat is counted, abort wins (IDLE, aborted=1, no done).
REQ-028 Monitor handshakes outside RUN SHALL be ignored.
REQ-029 packets_done and beats_done SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 On aresetn low, asynchronously: state IDLE, pkt_aresetn=0, pkt_config=0, busy=0, done=0, aborted=0, cfg_error=0, irq=0, counters 0.
REQ-031 Reset mid-RUN SHALL discard the acquisition with no done pulse; first edge after release operates from IDLE.

Configuration
REQ-032 With macro ACQ_SEQUENCER_IRQ_EN defined: irq set on the cycle done or aborted rises, held until irq_ack high; simultaneous set and ack -> irq stays 1.
REQ-033 Without ACQ_SEQUENCER_IRQ_EN: irq tied 0, irq_ack ignored, no IRQ register synthesized.

Verification
REQ-034 start, len=10, num=3, sink always ready -> pkt_aresetn low 2 cycles, 30 beats, packets_done=3, one done pulse, busy falls with done.
REQ-035 start with num=0 -> cfg_error=1, state IDLE, pkt_aresetn stays 0, busy never rises.
REQ-036 len=10, num=5, abort after 2nd tlast -> next cycle IDLE, aborted=1, packets_done=2, no done; irq=1 until irq_ack when IRQ enabled.
REQ-037 abort on same cycle as 3rd (final) tlast of num=3 -> packets_done=3, aborted=1, done never asserted.
REQ-038 second start pulse during RUN with different cfg -> ignored; acquisition completes with original len/num.
REQ-039 aresetn low mid-RUN -> all outputs at reset values immediately; subsequent start len=4, num=1 completes with packets_done=1, beats_done=4.
